sparc_control_unit: RTL and testbench
=====================================

Name: sparc_control_unit

Overview:
- Hardwired Moore FSM that sits directly upstream of the SPARC datapath and drives every datapath control input.
- Consumes the datapath's IR output, MOC, BCOND and TCOND.
- Sequences fetch, decode and execute for a supported subset: format-3 ALU ops (reg/imm), LD, ST, Bicc and CALL.
- Any other opcode halts the FSM with an error flag.

Parameters:
- OP_ADD, 6'b000000, ALU opcode for add (address generation).
- OP_PASSA, 6'b111110, ALU opcode that passes operand A.
- OP_PASSB, 6'b111111, ALU opcode that passes operand B.
- MOC_LIMIT, 16, maximum cycles to wait for MOC before error.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Clr  in  1  synchronous active-high reset.
- IR  in  32  instruction register contents.
- MOC  in  1  memory operation complete.
- BCOND  in  1  branch condition true.
- TCOND  in  1  trap condition; unused in this subset.
- IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld  out  1 each  register load/clear strobes.
- RF_Load_Enable, Register_Windows_Enable  out  1 each  register-file write / window enable.
- WIM_Ld, TBR_Ld, TTR_Ld, PSR_Ld, RF_Clear_Enable, MF  out  1 each  constant 0 in this subset.
- RW  out  1  1 = read, 0 = write.
- MOV  out  1  memory operation valid.
- type  out  2  access size; always 2'b10 (word).
- MA, MB, MNP, MP, MSc  out  2 each  datapath mux selects.
- MC, MM, MR, MOP, MSa  out  1 each  datapath mux selects.
- OpXX  out  6  ALU opcode used when MOP=1.
- State  out  5  current state code (debug).
- Err  out  1  sticky error flag (illegal opcode or MOC timeout).

Behaviour:
- Outputs are a pure function of the current state (Moore), plus the field decodes named below.
- Every output not listed for a state is 0. Register_Windows_Enable=1 in all states except RST.
- Clr=1 at a posedge forces State=RST(0), Err=0 and the MOC counter to 0, regardless of the current state, including mid-memory-wait.

States (code, asserted outputs, next state):
- RST(0): MP=00, PC_Ld (PC←0); MNP=11, MR=1, NPC_Ld (NPC←4). → F1.
- F1(1): MB=10, MC=0, MOP=1, OpXX=OP_PASSB, MAR_Ld (MAR←PC). → F2.
- F2(2): MOV=1, RW=1, type=10.
  - Stay while MOC=0.
  - When MOC=1: IR_Ld=1, → DEC.
- DEC(3): no strobes. Decode op=IR[31:30]:
  - 10 with op3[5:3]≠111 → ALU.
  - 11 with op3=000000 → LA.
  - 11 with op3=000100 → SA.
  - 00 with op2=IR[24:22]=010 → BR.
  - 01 → C1.
  - Anything else → ILL.
- ALU(4): MSa=0, MB=00 if IR[13]=0 else 01, MOP=0, MSc=00, RF_Load_Enable. FR_Ld=IR[23] (cc variants). → ADV.
- LA(5): MSa=0, MB=IR[13]?01:00, MOP=1, OpXX=OP_ADD, MAR_Ld. → LM.
- LM(6): MOV=1, RW=1, MM=0.
  - Stay while MOC=0.
  - When MOC=1: MDR_Ld, → LW.
- LW(7): MB=11, MOP=1, OpXX=OP_PASSB, MSc=00, RF_Load_Enable. → ADV.
- SA(8): same outputs as LA. → SD.
- SD(9): MSa=1, MOP=1, OpXX=OP_PASSA, MM=1, MDR_Ld (MDR←r[rd]). → SM.
- SM(10): MOV=1, RW=0. Stay while MOC=0; when MOC=1 → ADV.
- BR(11): if BCOND: MP=11, PC_Ld; MNP=10, NPC_Ld (PC←NPC, NPC←PC+disp). → F1. If BCOND=0 → ADV.
- C1(12): MB=10, MC=0, MOP=1, OpXX=OP_PASSB, MSc=01, RF_Load_Enable (r15←PC). → C2.
- C2(13): MP=11, PC_Ld; MNP=10, NPC_Ld. → F1.
- ADV(14): MP=11, PC_Ld; MNP=11, MR=0, NPC_Ld (PC←NPC, NPC←NPC+4). → F1.
- ILL(15): Err=1. Hold in ILL until Clr.

MOC wait timing:
- In F2, LM and SM an 8-bit counter increments each cycle MOC=0 and clears on state exit.
- When the counter reaches MOC_LIMIT → ILL with Err=1.
- MOC=1 in the first wait cycle means zero extra cycles.

Latency:
- Minimum latency (MOC immediate): ALU = 5 cycles (F1, F2, DEC, ALU, ADV); LD = 7; ST = 7; taken Bicc = 4; CALL = 5.
- Annul bit, traps, window save/restore and PSR/WIM/TBR writes are not supported. They decode to ILL where applicable.

Test Plan:
- Reset: hold Clr 2 cycles → State=0, PC_Ld=1, MP=00, NPC_Ld=1, MNP=11, MR=1, Err=0. Next cycle State=1, MAR_Ld=1, MB=10.
- ALU imm: IR=0x8600_6005 (add %g1,5,%g3), MOC after 3 cycles → F2 held 3 cycles, then ALU with MB=01, MOP=0, RF_Load_Enable=1, FR_Ld=0; then ADV with MP=11, MNP=11, MR=0.
- LD/ST: IR=0xC400_6008 (ld), MOC at the first LM cycle → LM asserts MDR_Ld, LW asserts MB=11, RF_Load_Enable. IR=0xC420_6008 (st) → SD asserts MSa=1, MM=1, MDR_Ld; SM asserts RW=0, MOV=1.
- Bicc: IR=0x1280_0004 with BCOND=1 → BR asserts PC_Ld with MP=11, NPC_Ld with MNP=10, next State=1. Same IR with BCOND=0 → next State=14.
- CALL: IR=0x4000_0010 → C1 asserts MSc=01, MC=0, RF_Load_Enable. C2 asserts MNP=10, MP=11.
- Errors: IR=0x0000_0000 → ILL, Err=1, held for 20 cycles. MOC never asserted in F2 → ILL after 16 wait cycles. Clr mid-LM → State=0, Err=0 next cycle.

Source files
------------

// File: rtl/sparc_control_unit_if.sv
// Purpose: datapath-facing bundle for the SPARC control unit: IR/status in, control strobes and mux selects out.
// Latency: pure wiring, no storage.
// Backpressure: none; MOC is the only stall input and it is consumed by the control FSM.
// Ports: IR, MOC, BCOND, TCOND come from the datapath. Every other member is driven by the control unit.
// acc_type carries the memory access size; it cannot be called "type" because that is a reserved word.
interface sparc_control_unit_if;
    logic [31:0] IR;
    logic        MOC;
    logic        BCOND;
    logic        TCOND;

    logic        IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld;
    logic        RF_Load_Enable, Register_Windows_Enable;
    logic        WIM_Ld, TBR_Ld, TTR_Ld, PSR_Ld, RF_Clear_Enable, MF;
    logic        RW, MOV;
    logic [1:0]  acc_type;
    logic [1:0]  MA, MB, MNP, MP, MSc;
    logic        MC, MM, MR, MOP, MSa;
    logic [5:0]  OpXX;
    logic [4:0]  State;
    logic        Err;

    modport master (
        input  IR, MOC, BCOND, TCOND,
        output IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld,
               RF_Load_Enable, Register_Windows_Enable,
               WIM_Ld, TBR_Ld, TTR_Ld, PSR_Ld, RF_Clear_Enable, MF,
               RW, MOV, acc_type, MA, MB, MNP, MP, MSc,
               MC, MM, MR, MOP, MSa, OpXX, State, Err
    );

    modport slave (
        output IR, MOC, BCOND, TCOND,
        input  IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr, FR_Ld,
               RF_Load_Enable, Register_Windows_Enable,
               WIM_Ld, TBR_Ld, TTR_Ld, PSR_Ld, RF_Clear_Enable, MF,
               RW, MOV, acc_type, MA, MB, MNP, MP, MSc,
               MC, MM, MR, MOP, MSa, OpXX, State, Err
    );
endinterface

// File: rtl/sparc_control_unit.sv
// Purpose: hardwired FSM sequencing fetch/decode/execute of ALU, LD, ST, Bicc and CALL on the SPARC datapath.
// Latency: ALU 5, LD 7, ST 7, taken Bicc 4, CALL 5 cycles with immediate MOC; one extra cycle per MOC=0 wait.
// Backpressure: stalls in F2/LM/SM while MOC=0; MOC_LIMIT consecutive waits end in ILL with Err set.
// Ports: Clk, Clr (sync active-high reset) plus dp (master side of sparc_control_unit_if).
module sparc_control_unit #(
    parameter logic [5:0] OP_ADD    = 6'b000000,
    parameter logic [5:0] OP_PASSA  = 6'b111110,
    parameter logic [5:0] OP_PASSB  = 6'b111111,
    parameter int         MOC_LIMIT = 16
) (
    input  logic                   Clk,
    input  logic                   Clr,
    sparc_control_unit_if.master   dp
);

    typedef enum logic [4:0] {
        RST = 5'd0, F1, F2, DEC, ALU, LA, LM, LW, SA, SD, SM, BR, C1, C2, ADV, ILL
    } state_t;

    state_t     state, next_state;
    logic [7:0] moc_cnt;
    logic       in_wait;
    logic       moc_expired;
    logic [1:0] op;
    logic [5:0] op3;
    logic [2:0] op2;
    logic       unused_inputs;

    assign op  = dp.IR[31:30];
    assign op3 = dp.IR[24:19];
    assign op2 = dp.IR[24:22];

    // TCOND has no consumer in this instruction subset.
    assign unused_inputs = ^{dp.TCOND, dp.IR};

    assign in_wait     = (state == F2) || (state == LM) || (state == SM);
    // This is the last permitted wait cycle: counting it brings the count to MOC_LIMIT.
    assign moc_expired = (moc_cnt == 8'(MOC_LIMIT - 1));

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state   <= RST;
            moc_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                moc_cnt <= '0;
            else if (in_wait && !dp.MOC)
                moc_cnt <= moc_cnt + 8'd1;
        end
    end

    // Outputs that are fixed in this subset.
    assign dp.nPC_Clr         = 1'b0;
    assign dp.WIM_Ld          = 1'b0;
    assign dp.TBR_Ld          = 1'b0;
    assign dp.TTR_Ld          = 1'b0;
    assign dp.PSR_Ld          = 1'b0;
    assign dp.RF_Clear_Enable = 1'b0;
    assign dp.MF              = 1'b0;
    assign dp.MA              = 2'b00;
    assign dp.acc_type        = 2'b10;
    assign dp.State           = state;

    always_comb begin
        next_state                 = state;
        dp.IR_Ld                   = 1'b0;
        dp.MAR_Ld                  = 1'b0;
        dp.MDR_Ld                  = 1'b0;
        dp.PC_Ld                   = 1'b0;
        dp.NPC_Ld                  = 1'b0;
        dp.FR_Ld                   = 1'b0;
        dp.RF_Load_Enable          = 1'b0;
        dp.Register_Windows_Enable = 1'b1;
        dp.RW                      = 1'b0;
        dp.MOV                     = 1'b0;
        dp.MB                      = 2'b00;
        dp.MNP                     = 2'b00;
        dp.MP                      = 2'b00;
        dp.MSc                     = 2'b00;
        dp.MC                      = 1'b0;
        dp.MM                      = 1'b0;
        dp.MR                      = 1'b0;
        dp.MOP                     = 1'b0;
        dp.MSa                     = 1'b0;
        dp.OpXX                    = 6'b000000;
        dp.Err                     = 1'b0;

        case (state)
            RST: begin
                dp.Register_Windows_Enable = 1'b0;
                dp.PC_Ld  = 1'b1;              // PC <- 0
                dp.MNP    = 2'b11;
                dp.MR     = 1'b1;
                dp.NPC_Ld = 1'b1;              // NPC <- 4
                next_state = F1;
            end
            F1: begin
                dp.MB     = 2'b10;
                dp.MOP    = 1'b1;
                dp.OpXX   = OP_PASSB;
                dp.MAR_Ld = 1'b1;              // MAR <- PC
                next_state = F2;
            end
            F2: begin
                dp.MOV = 1'b1;
                dp.RW  = 1'b1;
                if (dp.MOC) begin
                    dp.IR_Ld   = 1'b1;
                    next_state = DEC;
                end else if (moc_expired) begin
                    next_state = ILL;
                end
            end
            DEC: begin
                case (op)
                    2'b10:   next_state = (op3[5:3] != 3'b111) ? ALU : ILL;
                    2'b11:   next_state = (op3 == 6'b000000) ? LA :
                                          (op3 == 6'b000100) ? SA : ILL;
                    2'b00:   next_state = (op2 == 3'b010) ? BR : ILL;
                    default: next_state = C1;
                endcase
            end
            ALU: begin
                dp.MB             = {1'b0, dp.IR[13]};
                dp.RF_Load_Enable = 1'b1;
                dp.FR_Ld          = dp.IR[23];  // cc variants update flags
                next_state        = ADV;
            end
            LA, SA: begin
                dp.MB      = {1'b0, dp.IR[13]};
                dp.MOP     = 1'b1;
                dp.OpXX    = OP_ADD;
                dp.MAR_Ld  = 1'b1;
                next_state = (state == LA) ? LM : SD;
            end
            LM: begin
                dp.MOV = 1'b1;
                dp.RW  = 1'b1;
                if (dp.MOC) begin
                    dp.MDR_Ld  = 1'b1;
                    next_state = LW;
                end else if (moc_expired) begin
                    next_state = ILL;
                end
            end
            LW: begin
                dp.MB             = 2'b11;
                dp.MOP            = 1'b1;
                dp.OpXX           = OP_PASSB;
                dp.RF_Load_Enable = 1'b1;
                next_state        = ADV;
            end
            SD: begin
                dp.MSa     = 1'b1;
                dp.MOP     = 1'b1;
                dp.OpXX    = OP_PASSA;
                dp.MM      = 1'b1;
                dp.MDR_Ld  = 1'b1;             // MDR <- r[rd]
                next_state = SM;
            end
            SM: begin
                dp.MOV = 1'b1;
                if (dp.MOC)
                    next_state = ADV;
                else if (moc_expired)
                    next_state = ILL;
            end
            BR: begin
                if (dp.BCOND) begin
                    dp.MP      = 2'b11;
                    dp.PC_Ld   = 1'b1;         // PC <- NPC
                    dp.MNP     = 2'b10;
                    dp.NPC_Ld  = 1'b1;         // NPC <- PC + disp
                    next_state = F1;
                end else begin
                    next_state = ADV;
                end
            end
            C1: begin
                dp.MB             = 2'b10;
                dp.MOP            = 1'b1;
                dp.OpXX           = OP_PASSB;
                dp.MSc            = 2'b01;
                dp.RF_Load_Enable = 1'b1;      // r15 <- PC
                next_state        = C2;
            end
            C2: begin
                dp.MP      = 2'b11;
                dp.PC_Ld   = 1'b1;
                dp.MNP     = 2'b10;
                dp.NPC_Ld  = 1'b1;
                next_state = F1;
            end
            ADV: begin
                dp.MP      = 2'b11;
                dp.PC_Ld   = 1'b1;             // PC <- NPC
                dp.MNP     = 2'b11;
                dp.NPC_Ld  = 1'b1;             // NPC <- NPC + 4
                next_state = F1;
            end
            ILL: begin
                dp.Err     = 1'b1;
                next_state = ILL;
            end
            default: next_state = ILL;
        endcase
    end

endmodule

// File: tb/tb_sparc_control_unit.sv
// Purpose: self-checking bench for sparc_control_unit driven cycle by cycle from a vector table plus corner sequences.
// Latency: one vector per clock; outputs sampled on the falling edge.
// Backpressure: MOC is driven per vector to create memory waits.
module tb_sparc_control_unit;

    logic Clk;
    logic Clr;

    sparc_control_unit_if bus();

    sparc_control_unit dut (
        .Clk (Clk),
        .Clr (Clr),
        .dp  (bus.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [5:0] P_ADD   = 6'b000000;
    localparam logic [5:0] P_PASSA = 6'b111110;
    localparam logic [5:0] P_PASSB = 6'b111111;

    localparam logic [31:0] IR_ADD   = 32'h8600_6005;
    localparam logic [31:0] IR_ADDCC = 32'h8680_6005;
    localparam logic [31:0] IR_LD    = 32'hC400_6008;
    localparam logic [31:0] IR_ST    = 32'hC420_6008;
    localparam logic [31:0] IR_BR    = 32'h1280_0004;
    localparam logic [31:0] IR_CALL  = 32'h4000_0010;
    localparam logic [31:0] IR_BAD   = 32'h0000_0000;

    typedef struct packed {
        logic [4:0] st;
        logic       err;
        logic       ir_ld, mar_ld, mdr_ld, pc_ld, npc_ld, fr_ld, rf_le, rwe;
        logic       rw, mov;
        logic [1:0] mb, mnp, mp, msc;
        logic       mc, mm, mr, mop, msa;
        logic [5:0] opxx;
    } out_t;

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        moc;
        logic        bcond;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Expected output words, one per state, written from the state table.
    function automatic out_t base(input logic [4:0] s);
        out_t o;
        o     = '0;
        o.st  = s;
        o.rwe = 1'b1;
        return o;
    endfunction
    function automatic out_t e_rst();
        out_t o = base(5'd0);
        o.rwe = 1'b0; o.pc_ld = 1'b1; o.mp = 2'b00; o.mnp = 2'b11; o.mr = 1'b1; o.npc_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_f1();
        out_t o = base(5'd1);
        o.mb = 2'b10; o.mop = 1'b1; o.opxx = P_PASSB; o.mar_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_f2(input logic moc);
        out_t o = base(5'd2);
        o.mov = 1'b1; o.rw = 1'b1; o.ir_ld = moc;
        return o;
    endfunction
    function automatic out_t e_dec();
        return base(5'd3);
    endfunction
    function automatic out_t e_alu(input logic i13, input logic i23);
        out_t o = base(5'd4);
        o.mb = {1'b0, i13}; o.rf_le = 1'b1; o.fr_ld = i23;
        return o;
    endfunction
    function automatic out_t e_addr(input logic [4:0] s, input logic i13);
        out_t o = base(s);
        o.mb = {1'b0, i13}; o.mop = 1'b1; o.opxx = P_ADD; o.mar_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_lm(input logic moc);
        out_t o = base(5'd6);
        o.mov = 1'b1; o.rw = 1'b1; o.mdr_ld = moc;
        return o;
    endfunction
    function automatic out_t e_lw();
        out_t o = base(5'd7);
        o.mb = 2'b11; o.mop = 1'b1; o.opxx = P_PASSB; o.rf_le = 1'b1;
        return o;
    endfunction
    function automatic out_t e_sd();
        out_t o = base(5'd9);
        o.msa = 1'b1; o.mop = 1'b1; o.opxx = P_PASSA; o.mm = 1'b1; o.mdr_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_sm();
        out_t o = base(5'd10);
        o.mov = 1'b1;
        return o;
    endfunction
    function automatic out_t e_br(input logic b);
        out_t o = base(5'd11);
        if (b) begin
            o.mp = 2'b11; o.pc_ld = 1'b1; o.mnp = 2'b10; o.npc_ld = 1'b1;
        end
        return o;
    endfunction
    function automatic out_t e_c1();
        out_t o = base(5'd12);
        o.mb = 2'b10; o.mop = 1'b1; o.opxx = P_PASSB; o.msc = 2'b01; o.rf_le = 1'b1;
        return o;
    endfunction
    function automatic out_t e_c2();
        out_t o = base(5'd13);
        o.mp = 2'b11; o.pc_ld = 1'b1; o.mnp = 2'b10; o.npc_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_adv();
        out_t o = base(5'd14);
        o.mp = 2'b11; o.pc_ld = 1'b1; o.mnp = 2'b11; o.npc_ld = 1'b1;
        return o;
    endfunction
    function automatic out_t e_ill();
        out_t o = base(5'd15);
        o.err = 1'b1;
        return o;
    endfunction

    function automatic vec_t mk(input logic clr, input logic [31:0] ir, input logic moc,
                                input logic bcond, input out_t exp);
        vec_t v;
        v.clr = clr; v.ir = ir; v.moc = moc; v.bcond = bcond; v.exp = exp;
        return v;
    endfunction

    task automatic add(input logic clr, input logic [31:0] ir, input logic moc,
                       input logic bcond, input out_t exp);
        tbl.push_back(mk(clr, ir, moc, bcond, exp));
    endtask

    function automatic out_t sample();
        out_t o;
        o.st = bus.State; o.err = bus.Err;
        o.ir_ld = bus.IR_Ld; o.mar_ld = bus.MAR_Ld; o.mdr_ld = bus.MDR_Ld;
        o.pc_ld = bus.PC_Ld; o.npc_ld = bus.NPC_Ld; o.fr_ld = bus.FR_Ld;
        o.rf_le = bus.RF_Load_Enable; o.rwe = bus.Register_Windows_Enable;
        o.rw = bus.RW; o.mov = bus.MOV;
        o.mb = bus.MB; o.mnp = bus.MNP; o.mp = bus.MP; o.msc = bus.MSc;
        o.mc = bus.MC; o.mm = bus.MM; o.mr = bus.MR; o.mop = bus.MOP; o.msa = bus.MSa;
        o.opxx = bus.OpXX;
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        out_t e;
        out_t got;
        logic [10:0] fixed_got;
        Clr        = v.clr;
        bus.IR     = v.ir;
        bus.MOC    = v.moc;
        bus.BCOND  = v.bcond;
        exp_q.push_back(v.exp);
        @(negedge Clk);
        got = sample();
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no expectation queued, got state=%0d", tag, got.st);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got state=%0d word=%h, want state=%0d word=%h",
                         tag, got.st, got, e.st, e);
            end
        end
        fixed_got = {bus.nPC_Clr, bus.WIM_Ld, bus.TBR_Ld, bus.TTR_Ld, bus.PSR_Ld,
                     bus.RF_Clear_Enable, bus.MF, bus.MA, bus.acc_type};
        total++;
        if (fixed_got !== 11'b000_0000_0010) begin
            bad++;
            $display("FAIL %s_fixed: got %b, want 00000000010", tag, fixed_got);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clr       = 1'b1;
        bus.IR    = '0;
        bus.MOC   = 1'b0;
        bus.BCOND = 1'b0;
        bus.TCOND = 1'b0;
        @(posedge Clk);
        #1;

        // Reset held two cycles, then ALU immediate with MOC on the third F2 cycle.
        add(1, IR_ADD, 0, 0, e_rst());
        add(0, IR_ADD, 0, 0, e_rst());
        add(0, IR_ADD, 0, 0, e_f1());
        add(0, IR_ADD, 0, 0, e_f2(0));
        add(0, IR_ADD, 0, 0, e_f2(0));
        add(0, IR_ADD, 1, 0, e_f2(1));
        add(0, IR_ADD, 0, 0, e_dec());
        add(0, IR_ADD, 0, 0, e_alu(1, 0));
        add(0, IR_ADD, 0, 0, e_adv());
        // ALU cc variant raises FR_Ld.
        add(0, IR_ADDCC, 0, 0, e_f1());
        add(0, IR_ADDCC, 1, 0, e_f2(1));
        add(0, IR_ADDCC, 0, 0, e_dec());
        add(0, IR_ADDCC, 0, 0, e_alu(1, 1));
        add(0, IR_ADDCC, 0, 0, e_adv());
        // Load with immediate MOC.
        add(0, IR_LD, 0, 0, e_f1());
        add(0, IR_LD, 1, 0, e_f2(1));
        add(0, IR_LD, 0, 0, e_dec());
        add(0, IR_LD, 0, 0, e_addr(5'd5, 1));
        add(0, IR_LD, 1, 0, e_lm(1));
        add(0, IR_LD, 0, 0, e_lw());
        add(0, IR_LD, 0, 0, e_adv());
        // Store with one wait cycle in SM.
        add(0, IR_ST, 0, 0, e_f1());
        add(0, IR_ST, 1, 0, e_f2(1));
        add(0, IR_ST, 0, 0, e_dec());
        add(0, IR_ST, 0, 0, e_addr(5'd8, 1));
        add(0, IR_ST, 0, 0, e_sd());
        add(0, IR_ST, 0, 0, e_sm());
        add(0, IR_ST, 1, 0, e_sm());
        add(0, IR_ST, 0, 0, e_adv());
        // Bicc taken, then not taken.
        add(0, IR_BR, 0, 1, e_f1());
        add(0, IR_BR, 1, 1, e_f2(1));
        add(0, IR_BR, 0, 1, e_dec());
        add(0, IR_BR, 0, 1, e_br(1));
        add(0, IR_BR, 0, 0, e_f1());
        add(0, IR_BR, 1, 0, e_f2(1));
        add(0, IR_BR, 0, 0, e_dec());
        add(0, IR_BR, 0, 0, e_br(0));
        add(0, IR_BR, 0, 0, e_adv());
        // CALL.
        add(0, IR_CALL, 0, 0, e_f1());
        add(0, IR_CALL, 1, 0, e_f2(1));
        add(0, IR_CALL, 0, 0, e_dec());
        add(0, IR_CALL, 0, 0, e_c1());
        add(0, IR_CALL, 0, 0, e_c2());
        // Illegal opcode up to decode.
        add(0, IR_BAD, 0, 0, e_f1());
        add(0, IR_BAD, 1, 0, e_f2(1));
        add(0, IR_BAD, 0, 0, e_dec());

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("tbl%0d", i));

        // ILL holds with Err for 20 cycles regardless of MOC, then Clr recovers.
        for (int i = 0; i < 20; i++)
            run_vec(mk(0, IR_BAD, 1, 1, e_ill()), $sformatf("ill_hold%0d", i));
        run_vec(mk(1, IR_BAD, 0, 0, e_ill()), "ill_clr");
        run_vec(mk(0, IR_ADD, 0, 0, e_rst()), "ill_rst");

        // MOC never arrives: 16 wait cycles in F2, then ILL.
        run_vec(mk(0, IR_ADD, 0, 0, e_f1()), "to_f1");
        for (int i = 0; i < 16; i++)
            run_vec(mk(0, IR_ADD, 0, 0, e_f2(0)), $sformatf("to_wait%0d", i));
        run_vec(mk(0, IR_ADD, 0, 0, e_ill()), "to_ill");
        run_vec(mk(1, IR_ADD, 0, 0, e_ill()), "to_clr");
        run_vec(mk(0, IR_LD, 0, 0, e_rst()), "to_rst");

        // Clr while waiting in LM returns to RST with Err clear.
        run_vec(mk(0, IR_LD, 0, 0, e_f1()), "cl_f1");
        run_vec(mk(0, IR_LD, 1, 0, e_f2(1)), "cl_f2");
        run_vec(mk(0, IR_LD, 0, 0, e_dec()), "cl_dec");
        run_vec(mk(0, IR_LD, 0, 0, e_addr(5'd5, 1)), "cl_la");
        run_vec(mk(0, IR_LD, 0, 0, e_lm(0)), "cl_lm0");
        run_vec(mk(1, IR_LD, 0, 0, e_lm(0)), "cl_lm1");
        run_vec(mk(0, IR_LD, 0, 0, e_rst()), "cl_rst");
        run_vec(mk(0, IR_LD, 0, 0, e_f1()), "cl_f1b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
